mem_arbiter: RTL

Two-requester round-robin arbiter that shares one single-port 8-bit `memory_module` (256 x 8) between two independent masters. It accepts at most one access per clock, drives the memory's `we`/`addr`/`data_in` from registers, and routes registered read data back to the requester that issued the read. It sits directly in front of `memory_module`; both masters see a simple valid/ready request port and a valid-only read-response port.

---
 rtl/mem_arbiter.sv | 73 +++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a 256x8 single-port memory
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata/ready  request ports (valid/ready), N = 0, 1
//   rspN_rvalid/rdata               read responses, rvalid is a one-cycle pulse
//   mem_we/addr/wdata/rdata         registered command to memory, read data back
module mem_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_we,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_we,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       rsp0_rvalid,
  output logic [7:0] rsp0_rdata,
  output logic       rsp1_rvalid,
  output logic [7:0] rsp1_rdata,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);
  logic                ptr, gnt0, gnt1, cmd_rd, cmd_id;
  logic [READ_LAT-1:0] pv, pid;
  assign gnt0 = rst_n & req0_valid & (~req1_valid | ~ptr);
  assign gnt1 = rst_n & req1_valid & (~req0_valid | ptr);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  // cmd_rd/cmd_id travel alongside the mem_* command; the pipeline then delays
  // the tag so it exits exactly when mem_rdata carries that read's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cmd_rd      <= 1'b0;
      cmd_id      <= 1'b0;
      pv          <= '0;
      pid         <= '0;
      rsp0_rvalid <= 1'b0;
      rsp1_rvalid <= 1'b0;
      rsp0_rdata  <= '0;
      rsp1_rdata  <= '0;
    end else begin
      ptr    <= gnt0 ? 1'b1 : gnt1 ? 1'b0 : ptr;
      mem_we <= gnt0 ? req0_we : gnt1 ? req1_we : 1'b0;
      if (gnt0 | gnt1) begin
        mem_addr  <= gnt0 ? req0_addr : req1_addr;
        mem_wdata <= gnt0 ? req0_wdata : req1_wdata;
      end
      cmd_rd <= (gnt0 & ~req0_we) | (gnt1 & ~req1_we);
      cmd_id <= gnt1;
      pv[0]  <= cmd_rd;
      pid[0] <= cmd_id;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
      rsp0_rvalid <= pv[READ_LAT-1] & ~pid[READ_LAT-1];
      rsp1_rvalid <= pv[READ_LAT-1] & pid[READ_LAT-1];
      if (pv[READ_LAT-1] & ~pid[READ_LAT-1]) rsp0_rdata <= mem_rdata;
      if (pv[READ_LAT-1] & pid[READ_LAT-1]) rsp1_rdata <= mem_rdata;
    end
  end
endmodule
